// File: rtl/ysyx_25030081_mem_arbiter_pkg.sv
// ysyx_25030081_mem_arbiter_pkg: shared encodings and defaults for the IFU/LSU memory arbiter.
package ysyx_25030081_mem_arbiter_pkg;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RSP  = 2'd2,
      ST_ERR  = 2'd3
   } state_e;

   typedef enum logic {
      OWN_IFU = 1'b0,
      OWN_LSU = 1'b1
   } owner_e;

   localparam int TIMEOUT_DEFAULT = 255;

   function automatic int timer_width(input int t);
      return (t < 1) ? 1 : $clog2(t + 1);
   endfunction
endpackage

// File: rtl/ysyx_25030081_rr_arb2.sv
// ysyx_25030081_rr_arb2: combinational 2-way round-robin picker favouring the requester not granted last.
module ysyx_25030081_rr_arb2
   import ysyx_25030081_mem_arbiter_pkg::*;
(
   input  logic   v_ifu,
   input  logic   v_lsu,
   input  owner_e last_grant,
   output owner_e grant,
   output logic   any_valid
);
   always_comb begin
      any_valid = v_ifu | v_lsu;
      grant = (v_ifu && v_lsu) ? ((last_grant == OWN_IFU) ? OWN_LSU : OWN_IFU)
                               : (v_lsu ? OWN_LSU : OWN_IFU);
   end
endmodule

// File: rtl/ysyx_25030081_mem_arbiter.sv
// ysyx_25030081_mem_arbiter: shares one memory port between IFU and LSU with
// round-robin grant, one outstanding transaction and a response timeout.
module ysyx_25030081_mem_arbiter
   import ysyx_25030081_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ifu_req_valid,
   output logic                ifu_req_ready,
   input  logic [ADDR_W-1:0]   ifu_addr,
   output logic                ifu_rsp_valid,
   input  logic                ifu_rsp_ready,
   output logic [DATA_W-1:0]   ifu_rdata,
   output logic                ifu_rsp_err,
   input  logic                lsu_req_valid,
   output logic                lsu_req_ready,
   input  logic [ADDR_W-1:0]   lsu_addr,
   input  logic                lsu_wen,
   input  logic [DATA_W-1:0]   lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_wmask,
   output logic                lsu_rsp_valid,
   input  logic                lsu_rsp_ready,
   output logic [DATA_W-1:0]   lsu_rdata,
   output logic                lsu_rsp_err,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_wen,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic                mem_rsp_valid,
   output logic                mem_rsp_ready,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                mem_rsp_err
);
   localparam int TW = timer_width(TIMEOUT_CYCLES);

   state_e        state_q, state_d;
   owner_e        owner_q, owner_d;
   owner_e        last_q, last_d;
   logic [TW-1:0] timer_q, timer_d;

   owner_e              grant;
   logic                any_valid;
   logic                is_lsu;
   logic                own_rsp_ready;
   logic                timeout;
   logic                req_v;
   logic                req_rdy;
   logic                rsp_v;
   logic                rsp_err;
   logic [DATA_W-1:0]   rsp_data;

   ysyx_25030081_rr_arb2 u_rr (
      .v_ifu      (ifu_req_valid),
      .v_lsu      (lsu_req_valid),
      .last_grant (last_q),
      .grant      (grant),
      .any_valid  (any_valid)
   );

   assign is_lsu        = (owner_q == OWN_LSU);
   assign own_rsp_ready = is_lsu ? lsu_rsp_ready : ifu_rsp_ready;
   assign timeout       = (TIMEOUT_CYCLES != 0) && (timer_q == TW'(TIMEOUT_CYCLES));

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      last_d        = last_q;
      timer_d       = timer_q;
      req_v         = 1'b0;
      req_rdy       = 1'b0;
      rsp_v         = 1'b0;
      rsp_err       = 1'b0;
      rsp_data      = '0;
      mem_rsp_ready = 1'b0;
      case (state_q)
         ST_IDLE: begin
            timer_d = '0;
            if (any_valid) begin
               owner_d = grant;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            timer_d = timer_q + TW'(1);
            if (timeout) state_d = ST_ERR;
            else begin
               req_v   = 1'b1;
               req_rdy = mem_req_ready;
               if (mem_req_ready) state_d = ST_RSP;
            end
         end
         ST_RSP: begin
            timer_d = timer_q + TW'(1);
            if (timeout) state_d = ST_ERR;
            else begin
               mem_rsp_ready = own_rsp_ready;
               rsp_v         = mem_rsp_valid;
               rsp_err       = mem_rsp_valid & mem_rsp_err;
               rsp_data      = mem_rsp_valid ? mem_rdata : '0;
               if (mem_rsp_valid && own_rsp_ready) begin
                  state_d = ST_IDLE;
                  last_d  = owner_q;
               end
            end
         end
         ST_ERR: begin
            // Synthesised error response; any late slave response is ignored.
            timer_d = '0;
            rsp_v   = 1'b1;
            rsp_err = 1'b1;
            if (own_rsp_ready) begin
               state_d = ST_IDLE;
               last_d  = owner_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign mem_req_valid = req_v;
   assign mem_addr      = req_v ? (is_lsu ? lsu_addr : ifu_addr) : '0;
   assign mem_wen       = req_v & is_lsu & lsu_wen;
   assign mem_wdata     = (req_v && is_lsu) ? lsu_wdata : '0;
   assign mem_wmask     = (req_v && is_lsu) ? lsu_wmask : '0;

   assign ifu_req_ready = req_rdy & ~is_lsu;
   assign lsu_req_ready = req_rdy & is_lsu;
   assign ifu_rsp_valid = rsp_v & ~is_lsu;
   assign lsu_rsp_valid = rsp_v & is_lsu;
   assign ifu_rsp_err   = rsp_err & ~is_lsu;
   assign lsu_rsp_err   = rsp_err & is_lsu;
   assign ifu_rdata     = is_lsu ? '0 : rsp_data;
   assign lsu_rdata     = is_lsu ? rsp_data : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         owner_q <= OWN_IFU;
         last_q  <= OWN_LSU;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         timer_q <= timer_d;
      end
   end
endmodule

// File: doc/ysyx_25030081_mem_arbiter.md
Name: ysyx_25030081_mem_arbiter

Overview:
- Shares the single memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write) of the multi-cycle core.
- Uses a valid/ready request/response handshake with one outstanding transaction.
- Round-robin grant between the two requesters, plus a response timeout that returns an error to the owner if the slave hangs.
- Sits between the IFU/LSU and the SRAM/bus bridge.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; wmask width is DATA_W/8.
- TIMEOUT_CYCLES, 255, cycles allowed in REQ+RSP before error response; 0 disables timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- ifu_req_valid/ifu_req_ready  in/out  1/1  IFU request handshake.
- ifu_addr  in  ADDR_W  IFU fetch address.
- ifu_rsp_valid/ifu_rsp_ready  out/in  1/1  IFU response handshake.
- ifu_rdata  out  DATA_W  IFU read data.
- ifu_rsp_err  out  1  IFU error flag.
- lsu_req_valid/lsu_req_ready  in/out  1/1  LSU request handshake.
- lsu_addr  in  ADDR_W  LSU address.
- lsu_wen  in  1  LSU write enable.
- lsu_wdata  in  DATA_W  LSU write data.
- lsu_wmask  in  DATA_W/8  LSU byte mask.
- lsu_rsp_valid/lsu_rsp_ready  out/in  1/1  LSU response handshake.
- lsu_rdata  out  DATA_W  LSU read data.
- lsu_rsp_err  out  1  LSU error flag.
- mem_req_valid/mem_req_ready  out/in  1/1  slave request handshake.
- mem_addr/mem_wen/mem_wdata/mem_wmask  out  ADDR_W/1/DATA_W/DATA_W/8  slave request fields.
- mem_rsp_valid/mem_rsp_ready  in/out  1/1  slave response handshake.
- mem_rdata  in  DATA_W  slave read data.
- mem_rsp_err  in  1  slave error flag.

Behaviour:
- Reset:
  - State IDLE, owner=IFU, last_grant=LSU, timer=0.
  - All valid/ready outputs 0; data outputs 0.
  - Reset mid-transaction aborts it immediately; no response is delivered.
- States: IDLE, REQ, RSP, ERR.
- IDLE:
  - If only one requester is valid, grant it.
  - If both are valid, grant the one not equal to last_grant.
  - Register the owner and go to REQ; timer clears.
  - No ready is given in IDLE (one-cycle arbitration bubble).
- REQ:
  - mem_req_valid=1; mem fields are muxed from the owner.
  - For an IFU owner: mem_wen=0, mem_wmask=0, mem_wdata=0.
  - Owner req_ready = mem_req_ready; the non-owner req_ready=0.
  - On handshake, go to RSP.
- RSP:
  - mem_rsp_ready = owner rsp_ready.
  - Owner rsp_valid/rdata/rsp_err are passed through from mem.
  - On handshake: go to IDLE and set last_grant=owner.
- Timeout:
  - Timer increments every cycle in REQ or RSP.
  - If it reaches TIMEOUT_CYCLES without the RSP handshake, go to ERR; mem_req_valid and mem_rsp_ready drop that cycle.
- ERR:
  - Owner rsp_valid=1, rsp_err=1, rdata=0.
  - On owner rsp_ready, go to IDLE and set last_grant=owner.
  - Late slave responses after a timeout are a slave protocol violation and are not absorbed.
- Requesters must hold valid and fields stable until req_ready. The arbiter does not re-arbitrate once in REQ, even if the owner drops valid.
- Non-owner outputs are 0 in every state.
- Best latency:
  - valid in IDLE at cycle 0.
  - mem_req handshake at cycle 1.
  - mem_rsp handshake at cycle 2.
  - Back in IDLE at cycle 3.
- Back-to-back requests with both requesters continuously valid alternate strictly IFU, LSU, IFU, …

Decomposition:
- Shared package holds:
  - State encoding: IDLE=2'd0, REQ=2'd1, RSP=2'd2, ERR=2'd3.
  - Owner encoding: IFU=1'b0, LSU=1'b1.
  - Default TIMEOUT_CYCLES.
- One natural sub-module: ysyx_25030081_rr_arb2, the combinational 2-way round-robin picker (inputs: two valids and last_grant; output: grant index plus any-valid).

Test Plan:
- IFU only: ifu_addr=0x80000000, slave ready and responds with rdata=0x00000413 the next cycle → ifu_rsp_valid at cycle 2 with rdata 0x00000413, err=0; LSU outputs stay 0.
- Simultaneous requests after reset (last_grant=LSU) → IFU granted first; LSU write (addr=0x80001000, wdata=0xDEADBEEF, wmask=0xF) is forwarded next with mem_wen=1.
- Both requesters continuously valid for 6 transactions → grant order IFU, LSU, IFU, LSU, IFU, LSU.
- TIMEOUT_CYCLES=4, slave never asserts mem_req_ready → owner gets rsp_valid=1, rsp_err=1, rdata=0 after 4 cycles in REQ; returns to IDLE on rsp_ready.
- Owner holds rsp_ready=0 for 3 cycles while mem_rsp_valid=1 → mem_rsp_ready=0 for those cycles; data is held; a single handshake follows.
- rst asserted while in RSP → all outputs 0 asynchronously; the next request sees the IDLE bubble and arbitration restarts with IFU preferred.
